// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encodings and clock edge selectors for the PC sequencer
package pc_sequencer_pkg;
  localparam bit POS_EDGE = 1'b1;
  localparam bit NEG_EDGE = 1'b0;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with call/return stack control, depth tracking and sticky faults
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int addr_width = 4,
  parameter int data_width = 8,
  parameter logic [data_width-1:0] reset_vector = '0,
  parameter bit active_edge = POS_EDGE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  jmp,
  input  logic                  call,
  input  logic                  rtrn,
  input  logic [data_width-1:0] i_target,
  input  logic [data_width-1:0] i_Stack,
  output logic [data_width-1:0] o_PC,
  output logic                  o_call,
  output logic                  o_rtrn,
  output logic                  o_stall,
  output logic [addr_width:0]   o_depth,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam logic [addr_width:0] FULL = (addr_width+1)'(1) << addr_width;
  state_t r_state;
  logic w_clk;
  logic w_run;
  logic w_full;
  logic w_empty;
  assign w_clk   = active_edge ? clk : ~clk;
  assign w_run   = en && r_state == ST_RUN;
  assign w_full  = o_depth == FULL;
  assign w_empty = o_depth == '0;
  assign o_rtrn  = w_run && rtrn && !w_empty;
  assign o_call  = w_run && !rtrn && call && !w_full;
  assign o_stall = r_state != ST_RUN;
  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      o_PC        <= reset_vector;
      o_depth     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (en) begin
      case (r_state)
        ST_RUN: begin
          if (rtrn) begin
            if (!w_empty) begin
              o_depth <= o_depth - 1'b1;
              r_state <= ST_RET_WAIT;
            end else begin
              o_underflow <= 1'b1;
              r_state     <= ST_FAULT;
            end
          end else if (call) begin
            if (!w_full) begin
              o_PC    <= i_target;
              o_depth <= o_depth + 1'b1;
            end else begin
              o_overflow <= 1'b1;
              r_state    <= ST_FAULT;
            end
          end else begin
            o_PC <= jmp ? i_target : o_PC + 1'b1;
          end
        end
        ST_RET_WAIT: begin
          o_PC    <= i_Stack;
          r_state <= ST_RUN;
        end
        default: r_state <= ST_FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer against a behavioural return-address stack
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       jmp = 1'b0;
  logic       call = 1'b0;
  logic       rtrn = 1'b0;
  logic [7:0] i_target = '0;
  logic [7:0] i_Stack;
  logic [7:0] o_PC;
  logic       o_call;
  logic       o_rtrn;
  logic       o_stall;
  logic [4:0] o_depth;
  logic       o_overflow;
  logic       o_underflow;
  int tests = 0;
  int fails = 0;
  logic [7:0] mem [16];
  int sp;
  pc_sequencer #(.addr_width(4), .data_width(8)) dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .call(call), .rtrn(rtrn),
    .i_target(i_target), .i_Stack(i_Stack), .o_PC(o_PC), .o_call(o_call),
    .o_rtrn(o_rtrn), .o_stall(o_stall), .o_depth(o_depth),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= 0;
      i_Stack <= '0;
    end else if (o_call) begin
      mem[sp] <= o_PC + 8'd1;
      sp      <= sp + 1;
    end else if (o_rtrn) begin
      i_Stack <= mem[sp-1];
      sp      <= sp - 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("rst_pc", o_PC, 0);
    check("rst_depth", o_depth, 0);
    check("rst_flags", {o_overflow, o_underflow, o_stall, o_call, o_rtrn}, 0);
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      check("inc_pc", o_PC, i);
    end
    check("inc_depth", o_depth, 0);
    jmp = 1'b1; i_target = 8'hFE;
    tick;
    jmp = 1'b0;
    check("wrap_fe", o_PC, 8'hFE);
    tick;
    check("wrap_ff", o_PC, 8'hFF);
    tick;
    check("wrap_00", o_PC, 8'h00);
    jmp = 1'b1; i_target = 8'h10;
    tick;
    jmp = 1'b0;
    call = 1'b1; i_target = 8'h40;
    #1;
    check("call_strobe", o_call, 1);
    check("call_no_rtrn", o_rtrn, 0);
    tick;
    call = 1'b0;
    check("call_pc", o_PC, 8'h40);
    check("call_depth", o_depth, 1);
    tick;
    check("sub_pc", o_PC, 8'h41);
    rtrn = 1'b1;
    #1;
    check("rtrn_strobe", o_rtrn, 1);
    check("rtrn_no_call", o_call, 0);
    tick;
    rtrn = 1'b0;
    check("retwait_stall", o_stall, 1);
    check("retwait_pc", o_PC, 8'h41);
    check("retwait_depth", o_depth, 0);
    tick;
    check("ret_pc", o_PC, 8'h11);
    check("ret_stall", o_stall, 0);
    call = 1'b1; i_target = 8'h40;
    tick;
    check("pri_setup_depth", o_depth, 1);
    rtrn = 1'b1; i_target = 8'h80;
    #1;
    check("pri_rtrn", o_rtrn, 1);
    check("pri_call", o_call, 0);
    tick;
    call = 1'b0; rtrn = 1'b0;
    check("pri_stall", o_stall, 1);
    check("pri_depth", o_depth, 0);
    tick;
    check("pri_pc", o_PC, 8'h12);
    en = 1'b0; call = 1'b1; i_target = 8'h50;
    #1;
    check("en_call", o_call, 0);
    tick;
    check("en_pc", o_PC, 8'h12);
    check("en_depth", o_depth, 0);
    en = 1'b1; i_target = 8'h20;
    for (int i = 0; i < 16; i++) tick;
    check("nest_depth", o_depth, 16);
    check("nest_pc", o_PC, 8'h20);
    #1;
    check("ovf_no_call", o_call, 0);
    tick;
    call = 1'b0;
    check("ovf_flag", o_overflow, 1);
    check("ovf_stall", o_stall, 1);
    check("ovf_pc", o_PC, 8'h20);
    rtrn = 1'b1;
    #1;
    check("fault_no_rtrn", o_rtrn, 0);
    tick;
    rtrn = 1'b0;
    check("fault_pc", o_PC, 8'h20);
    check("fault_depth", o_depth, 16);
    check("fault_unf", o_underflow, 0);
    rst = 1'b0;
    #1;
    check("rst2_flags", {o_overflow, o_underflow, o_stall}, 0);
    check("rst2_depth", o_depth, 0);
    rst = 1'b1;
    call = 1'b1; i_target = 8'h30;
    tick;
    call = 1'b0;
    check("rw_call_pc", o_PC, 8'h30);
    rtrn = 1'b1;
    tick;
    rtrn = 1'b0;
    check("rw_stall", o_stall, 1);
    rst = 1'b0;
    #1;
    check("rw_rst_pc", o_PC, 0);
    check("rw_rst_stall", o_stall, 0);
    check("rw_rst_depth", o_depth, 0);
    rst = 1'b1;
    rtrn = 1'b1;
    #1;
    check("unf_no_rtrn", o_rtrn, 0);
    tick;
    rtrn = 1'b0;
    check("unf_flag", o_underflow, 1);
    check("unf_stall", o_stall, 1);
    tick;
    check("unf_pc", o_PC, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
